// File: rtl/tis_alu.sv
// TIS-100 node execute stage: operand resolve, saturating ACC arithmetic, blocking port I/O.
// Define TIS_ALU_STALL_CNT_EN to build the blocked-cycle counter behind stall_cnt.
module tis_alu #(
  parameter int ACC_MAX = 999
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [2:0]  opcode,
  input  logic [1:0]  src_sel,
  input  logic [10:0] imm,
  input  logic [10:0] acc_in,
  input  logic [10:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [10:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [10:0] new_acc,
  output logic        wen,
  output logic        sav,
  output logic        swp,
  output logic        done,
  output logic [15:0] stall_cnt
);

  localparam logic [2:0] OP_NOP = 3'd0, OP_MOV_ACC = 3'd1, OP_MOV_OUT = 3'd2, OP_ADD = 3'd3,
                         OP_SUB = 3'd4, OP_NEG = 3'd5, OP_SAV = 3'd6, OP_SWP = 3'd7;
  localparam logic [1:0] SRC_IMM = 2'd0, SRC_ACC = 2'd1, SRC_NIL = 2'd2, SRC_PORT = 2'd3;
  localparam logic signed [11:0] MAX_P = 12'(ACC_MAX);
  localparam logic signed [11:0] MAX_N = -MAX_P;

  typedef enum logic [1:0] {IDLE, RD_WAIT, EXEC, WR_WAIT} state_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [1:0]  src;
    logic [10:0] imm;
  } instr_t;

  function automatic logic [10:0] sat12(input logic signed [11:0] x);
    if (x > MAX_P)      return MAX_P[10:0];
    else if (x < MAX_N) return MAX_N[10:0];
    else                return x[10:0];
  endfunction

  function automatic logic [10:0] clamp11(input logic [10:0] x);
    return sat12({x[10], x});
  endfunction

  function automatic logic uses_src(input logic [2:0] op);
    return (op == OP_MOV_ACC) || (op == OP_MOV_OUT) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

  state_t             state;
  instr_t             ins_q;
  logic [10:0]        port_q;
  logic [10:0]        operand;
  logic signed [11:0] acc_x, opd_x;

  assign instr_ready = (state == IDLE);
  assign in_ready    = (state == RD_WAIT);
  assign out_valid   = (state == WR_WAIT);

  // acc_in is used live in EXEC so a back-to-back instruction sees the prior result
  always_comb begin
    operand = '0;
    case (ins_q.src)
      SRC_IMM:  operand = ins_q.imm;
      SRC_ACC:  operand = acc_in;
      SRC_NIL:  operand = '0;
      SRC_PORT: operand = port_q;
      default:  operand = '0;
    endcase
    acc_x   = {acc_in[10], acc_in};
    opd_x   = {operand[10], operand};
    new_acc = '0;
    wen     = 1'b0;
    sav     = 1'b0;
    swp     = 1'b0;
    if (state == EXEC && !RST) begin
      case (ins_q.op)
        OP_MOV_ACC: begin wen = 1'b1; new_acc = sat12(opd_x);          end
        OP_ADD:     begin wen = 1'b1; new_acc = sat12(acc_x + opd_x);  end
        OP_SUB:     begin wen = 1'b1; new_acc = sat12(acc_x - opd_x);  end
        OP_NEG:     begin wen = 1'b1; new_acc = sat12(12'sd0 - acc_x); end
        OP_SAV:     sav = 1'b1;
        OP_SWP:     swp = 1'b1;
        default:    ;
      endcase
    end
  end

  // a reset cycle never retires, even if a handshake completes in it
  assign done = !RST && (((state == EXEC) && (ins_q.op != OP_MOV_OUT)) ||
                         ((state == WR_WAIT) && out_ready));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      ins_q    <= '0;
      port_q   <= '0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: if (instr_valid) begin
          ins_q <= '{op: opcode, src: src_sel, imm: clamp11(imm)};
          state <= (src_sel == SRC_PORT && uses_src(opcode)) ? RD_WAIT : EXEC;
        end
        RD_WAIT: if (in_valid) begin
          port_q <= clamp11(in_data);
          if (ins_q.op == OP_MOV_OUT) begin
            out_data <= clamp11(in_data);
            state    <= WR_WAIT;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: if (ins_q.op == OP_MOV_OUT) begin
          out_data <= operand;
          state    <= WR_WAIT;
        end else begin
          state <= IDLE;
        end
        WR_WAIT: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TIS_ALU_STALL_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST)
      stall_cnt <= '0;
    else if (((state == RD_WAIT && !in_valid) || (state == WR_WAIT && !out_ready)) &&
             stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_tis_alu.sv
// Self-checking bench for tis_alu: directed corner cases plus randomized instructions
// checked against an integer-arithmetic reference model.
module tb_tis_alu;
  logic        CLK = 1'b0;
  logic        RST, instr_valid, instr_ready, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  opcode;
  logic [1:0]  src_sel;
  logic [10:0] imm, acc_in, in_data, out_data, new_acc;
  logic        wen, sav, swp, done;
  logic [15:0] stall_cnt;

  localparam int ACC_MAX = 999;
`ifdef TIS_ALU_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  tis_alu #(.ACC_MAX(ACC_MAX)) dut (
    .CLK(CLK), .RST(RST), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .src_sel(src_sel), .imm(imm), .acc_in(acc_in),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .new_acc(new_acc), .wen(wen), .sav(sav), .swp(swp), .done(done), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0, n_fail = 0;
  int exp_stall = 0;

  // observations gathered by run_instr
  int          o_rdy_acc, o_cycles, o_rd, o_wr, o_wen, o_sav, o_swp, o_done, o_done_at, o_bad;
  logic [10:0] o_new_acc, o_out;
  logic        o_out_unstable, o_rdy_after;

  // ---------------- reference model ----------------
  function automatic int sx(input logic [10:0] v);
    return int'($signed(v));
  endfunction
  function automatic int clampi(input int x);
    return (x > ACC_MAX) ? ACC_MAX : (x < -ACC_MAX) ? -ACC_MAX : x;
  endfunction
  function automatic bit uses_port(input logic [2:0] op, input logic [1:0] src);
    return (src == 2'd3) && (op >= 3'd1) && (op <= 3'd4);
  endfunction
  function automatic int ref_operand(input logic [1:0] src, input logic [10:0] im,
                                     input logic [10:0] acc, input logic [10:0] pd);
    case (src)
      2'd0:    return clampi(sx(im));
      2'd1:    return sx(acc);
      2'd2:    return 0;
      default: return clampi(sx(pd));
    endcase
  endfunction
  function automatic int ref_result(input logic [2:0] op, input int opd, input logic [10:0] acc);
    case (op)
      3'd1:    return clampi(opd);
      3'd2:    return opd;
      3'd3:    return clampi(sx(acc) + opd);
      3'd4:    return clampi(sx(acc) - opd);
      3'd5:    return clampi(-sx(acc));
      default: return 0;
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic run_instr(input logic [2:0] op, input logic [1:0] src, input logic [10:0] im,
                           input logic [10:0] acc, input logic [10:0] pdata,
                           input int pdelay, input int odelay);
    int rd_seen, wr_seen;
    opcode = op; src_sel = src; imm = im; acc_in = acc; instr_valid = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
    #1 o_rdy_acc = int'(instr_ready);
    @(posedge CLK); #1;
    instr_valid = 1'b0; imm = 11'($urandom); opcode = 3'($urandom); src_sel = 2'($urandom);
    o_cycles = 0; o_rd = 0; o_wr = 0; o_wen = 0; o_sav = 0; o_swp = 0; o_done = 0;
    o_done_at = 0; o_bad = 0; o_new_acc = '0; o_out = '0; o_out_unstable = 1'b0;
    rd_seen = 0; wr_seen = 0;
    for (int c = 0; c < 32; c++) begin
      in_valid  = in_ready && (rd_seen == pdelay);
      in_data   = in_valid ? pdata : 11'($urandom);
      out_ready = out_valid && (wr_seen == odelay);
      #1;
      o_cycles++;
      if (in_ready) begin rd_seen++; o_rd++; end
      if (out_valid) begin
        if (wr_seen > 0 && out_data !== o_out) o_out_unstable = 1'b1;
        o_out = out_data; wr_seen++; o_wr++;
      end
      if (wen) begin o_wen++; o_new_acc = new_acc; end
      else if (new_acc !== 11'd0) o_bad++;
      if (sav) o_sav++;
      if (swp) o_swp++;
      if (int'(wen) + int'(sav) + int'(swp) > 1) o_bad++;
      if (done) begin o_done++; o_done_at = o_cycles; end
      @(posedge CLK); #1;
      if (o_done > 0) break;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    o_rdy_after = instr_ready;
    exp_stall += (uses_port(op, src) ? pdelay : 0) + ((op == 3'd2) ? odelay : 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    RST = 1'b1; instr_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_instr_ready got %b want 1", instr_ready); end
    n_checks++; if ({in_ready, out_valid, wen, sav, swp, done} !== 6'b0) begin
      n_fail++; $display("FAIL reset_strobes got %b want 000000", {in_ready, out_valid, wen, sav, swp, done}); end
    n_checks++; if ({out_data, new_acc, stall_cnt} !== 38'd0) begin
      n_fail++; $display("FAIL reset_data out_data=%h new_acc=%h stall=%h want 0", out_data, new_acc, stall_cnt); end
    RST = 1'b0;
    exp_stall = 0;
  endtask

  task automatic test_saturation;
    run_instr(3'd3, 2'd0, 11'd20, 11'd990, 11'd0, 0, 0);
    n_checks++; if (o_wen !== 1 || o_new_acc !== 11'd999) begin n_fail++; $display("FAIL sat_add_hi wen=%0d new_acc=%0d want 1/999", o_wen, sx(o_new_acc)); end
    n_checks++; if (o_cycles !== 1 || o_done !== 1 || o_rdy_acc !== 1 || o_rdy_after !== 1'b1) begin
      n_fail++; $display("FAIL sat_add_timing cycles=%0d done=%0d rdy=%0d/%b want 1/1/1/1", o_cycles, o_done, o_rdy_acc, o_rdy_after); end
    run_instr(3'd1, 2'd0, 11'd1023, 11'd0, 11'd0, 0, 0);
    n_checks++; if (o_new_acc !== 11'd999) begin n_fail++; $display("FAIL sat_mov_imm got %0d want 999", sx(o_new_acc)); end
    run_instr(3'd4, 2'd0, 11'd999, 11'h7FB, 11'd0, 0, 0);
    n_checks++; if (o_new_acc !== 11'h419) begin n_fail++; $display("FAIL sat_sub_lo got %h want 419", o_new_acc); end
    run_instr(3'd5, 2'd0, 11'd0, 11'h419, 11'd0, 0, 0);
    n_checks++; if (o_wen !== 1 || o_new_acc !== 11'd999) begin n_fail++; $display("FAIL neg got %0d want 999", sx(o_new_acc)); end
  endtask

  task automatic test_port_read;
    run_instr(3'd3, 2'd3, 11'd0, 11'd10, 11'd7, 3, 0);
    n_checks++; if (o_rd !== 4 || o_cycles !== 5) begin n_fail++; $display("FAIL port_rd in_ready=%0d cycles=%0d want 4/5", o_rd, o_cycles); end
    n_checks++; if (o_wen !== 1 || o_new_acc !== 11'd17 || o_done_at !== 5) begin
      n_fail++; $display("FAIL port_rd_result wen=%0d new_acc=%0d done_at=%0d want 1/17/5", o_wen, sx(o_new_acc), o_done_at); end
    n_checks++; if (stall_cnt !== (STALL_EN ? 16'(exp_stall) : 16'd0)) begin
      n_fail++; $display("FAIL port_rd_stall got %0d want %0d", stall_cnt, STALL_EN ? exp_stall : 0); end
  endtask

  task automatic test_mov_out;
    run_instr(3'd2, 2'd1, 11'd0, 11'h7FF, 11'd0, 0, 2);
    n_checks++; if (o_wr !== 3 || o_out !== 11'h7FF || o_out_unstable !== 1'b0) begin
      n_fail++; $display("FAIL mov_out_wr out_valid=%0d out_data=%h unstable=%b want 3/7ff/0", o_wr, o_out, o_out_unstable); end
    n_checks++; if (o_done !== 1 || o_done_at !== 4 || o_wen + o_sav + o_swp !== 0 || o_bad !== 0) begin
      n_fail++; $display("FAIL mov_out_done done=%0d at=%0d strobes=%0d bad=%0d want 1/4/0/0", o_done, o_done_at, o_wen + o_sav + o_swp, o_bad); end
    n_checks++; if (out_data !== 11'h7FF) begin n_fail++; $display("FAIL mov_out_hold got %h want 7ff", out_data); end
  endtask

  task automatic test_back_to_back;
    run_instr(3'd7, 2'd0, 11'd0, 11'd5, 11'd0, 0, 0);
    n_checks++; if (o_swp !== 1 || o_sav !== 0 || o_wen !== 0) begin n_fail++; $display("FAIL b2b_swp swp=%0d sav=%0d wen=%0d want 1/0/0", o_swp, o_sav, o_wen); end
    run_instr(3'd6, 2'd3, 11'd0, 11'd5, 11'd0, 2, 0);
    n_checks++; if (o_sav !== 1 || o_swp !== 0 || o_cycles !== 1 || o_rd !== 0) begin
      n_fail++; $display("FAIL b2b_sav sav=%0d swp=%0d cycles=%0d rd=%0d want 1/0/1/0", o_sav, o_swp, o_cycles, o_rd); end
  endtask

  task automatic test_reset_mid;
    opcode = 3'd3; src_sel = 2'd3; imm = 11'd0; acc_in = 11'd1; instr_valid = 1'b1;
    @(posedge CLK); #1;
    instr_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_rd in_ready=%b want 1", in_ready); end
    in_valid = 1'b1; in_data = 11'd5; RST = 1'b1;
    #1;
    n_checks++; if (done !== 1'b0 || wen !== 1'b0) begin n_fail++; $display("FAIL rstmid_same done=%b wen=%b want 0/0", done, wen); end
    @(posedge CLK); #1;
    RST = 1'b0; in_valid = 1'b0; exp_stall = 0;
    n_checks++; if (instr_ready !== 1'b1 || in_ready !== 1'b0 || wen !== 1'b0 || done !== 1'b0 || stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL rstmid_next rdy=%b in_ready=%b wen=%b done=%b stall=%0d want 1/0/0/0/0", instr_ready, in_ready, wen, done, stall_cnt); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 80; i++) begin
      logic [2:0]  op  = 3'($urandom);
      logic [1:0]  src = 2'($urandom);
      logic [10:0] im  = 11'($urandom);
      logic [10:0] acc = 11'(int'($urandom_range(0, 1998)) - 999);
      logic [10:0] pd  = 11'($urandom);
      int pdl = int'($urandom_range(0, 3)), odl = int'($urandom_range(0, 3));
      bit port = uses_port(op, src);
      int res  = ref_result(op, ref_operand(src, im, acc, pd), acc);
      int e_wen = (op == 3'd1 || op == 3'd3 || op == 3'd4 || op == 3'd5) ? 1 : 0;
      int e_rd = port ? pdl + 1 : 0;
      int e_wr = (op == 3'd2) ? odl + 1 : 0;
      int e_cyc = e_rd + e_wr + ((op == 3'd2 && port) ? 0 : 1);
      run_instr(op, src, im, acc, pd, pdl, odl);
      n_checks++; if (o_cycles !== e_cyc || o_rd !== e_rd || o_wr !== e_wr) begin
        n_fail++; $display("FAIL rnd_timing i=%0d op=%0d src=%0d cyc/rd/wr=%0d/%0d/%0d want %0d/%0d/%0d", i, op, src, o_cycles, o_rd, o_wr, e_cyc, e_rd, e_wr); end
      n_checks++; if (o_wen !== e_wen || o_sav !== int'(op == 3'd6) || o_swp !== int'(op == 3'd7) || o_bad !== 0) begin
        n_fail++; $display("FAIL rnd_strobes i=%0d op=%0d wen/sav/swp/bad=%0d/%0d/%0d/%0d", i, op, o_wen, o_sav, o_swp, o_bad); end
      if (e_wen == 1) begin
        n_checks++; if (o_new_acc !== 11'(res)) begin n_fail++; $display("FAIL rnd_new_acc i=%0d op=%0d got %0d want %0d", i, op, sx(o_new_acc), res); end
      end
      if (op == 3'd2) begin
        n_checks++; if (o_out !== 11'(res) || o_out_unstable !== 1'b0) begin n_fail++; $display("FAIL rnd_out i=%0d got %0d want %0d", i, sx(o_out), res); end
      end
      n_checks++; if (o_done !== 1 || o_done_at !== e_cyc || o_rdy_after !== 1'b1) begin
        n_fail++; $display("FAIL rnd_done i=%0d done=%0d at=%0d rdy=%b want 1/%0d/1", i, o_done, o_done_at, o_rdy_after, e_cyc); end
      n_checks++; if (stall_cnt !== (STALL_EN ? 16'(exp_stall) : 16'd0)) begin
        n_fail++; $display("FAIL rnd_stall i=%0d got %0d want %0d", i, stall_cnt, STALL_EN ? exp_stall : 0); end
    end
  endtask

  initial begin
    RST = 1'b1; instr_valid = 1'b0; opcode = '0; src_sel = '0; imm = '0; acc_in = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    test_reset;
    test_saturation;
    test_port_read;
    test_mov_out;
    test_back_to_back;
    test_reset_mid;
    test_random;
    test_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
